// File: rtl/alu_branch_unit_if.sv
// Flag/branch bus between the ALU-side control and the branch unit.
// The master drives flags and branch requests; the slave returns PC and status.
interface alu_branch_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic                flag_we;
    logic                z_in;
    logic                s_in;
    logic                v_in;
    logic                pc_en;
    logic                br_valid;
    logic [2:0]          br_cond;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] pc;
    logic [2:0]          flags;
    logic                taken;
    logic                flush;
    logic                ready;

    modport master (
        output flag_we, z_in, s_in, v_in, pc_en, br_valid, br_cond, br_target,
        input  pc, flags, taken, flush, ready
    );

    modport slave (
        input  flag_we, z_in, s_in, v_in, pc_en, br_valid, br_cond, br_target,
        output pc, flags, taken, flush, ready
    );
endinterface

// File: rtl/alu_branch_unit.sv
// Latches ALU flags, resolves branch conditions against the registered flags,
// and owns the program counter including the post-branch flush window.
module alu_branch_unit #(
    parameter int PC_WIDTH     = 8,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    alu_branch_unit_if.slave bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
    localparam logic [3:0]          FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [0:0]          state;
    logic [3:0]          cnt;
    logic [PC_WIDTH-1:0] pc_q;
    logic [2:0]          flags_q;
    logic                taken_q;
    logic                cond_true;

    // Flags are packed {z, s, v}; LT/GE use the signed-compare sense s^v.
    function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] f);
        logic z, s, v;
        z = f[2];
        s = f[1];
        v = f[0];
        case (cond)
            3'b000:  eval_cond = 1'b1;
            3'b001:  eval_cond = z;
            3'b010:  eval_cond = !z;
            3'b011:  eval_cond = s ^ v;
            3'b100:  eval_cond = !(s ^ v);
            3'b101:  eval_cond = v;
            3'b110:  eval_cond = !v;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    assign cond_true = eval_cond(bus.br_cond, flags_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            cnt     <= 4'd0;
            pc_q    <= RESET_PC_V;
            flags_q <= 3'b000;
            taken_q <= 1'b0;
        end else begin
            if (bus.flag_we) begin
                flags_q <= {bus.z_in, bus.s_in, bus.v_in};
            end
            case (state)
                ST_RUN: begin
                    if (bus.br_valid && cond_true) begin
                        pc_q    <= bus.br_target;
                        taken_q <= 1'b1;
                        cnt     <= FLUSH_INIT;
                        state   <= ST_FLUSH;
                    end else begin
                        taken_q <= 1'b0;
                        if (bus.pc_en) begin
                            pc_q <= pc_q + PC_WIDTH'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // PC parks on the target while the wrong-path slots drain.
                    taken_q <= 1'b0;
                    if (cnt == 4'd0) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    taken_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc    = pc_q;
    assign bus.flags = flags_q;
    assign bus.taken = taken_q;
    assign bus.flush = (state == ST_FLUSH);
    assign bus.ready = (state == ST_RUN);
endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed bench for alu_branch_unit: one instance with a 1-cycle flush window
// and one with a 3-cycle window.
module tb_alu_branch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_branch_unit_if #(.PC_WIDTH(8)) bus0 ();
    alu_branch_unit_if #(.PC_WIDTH(8)) bus1 ();

    alu_branch_unit #(.PC_WIDTH(8), .RESET_PC(0), .FLUSH_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    alu_branch_unit #(.PC_WIDTH(8), .RESET_PC(0), .FLUSH_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.flag_we = 0; bus0.z_in = 0; bus0.s_in = 0; bus0.v_in = 0;
        bus0.pc_en = 0; bus0.br_valid = 0; bus0.br_cond = 3'b000; bus0.br_target = 8'h00;
    endtask

    task automatic idle1();
        bus1.flag_we = 0; bus1.z_in = 0; bus1.s_in = 0; bus1.v_in = 0;
        bus1.pc_en = 0; bus1.br_valid = 0; bus1.br_cond = 3'b000; bus1.br_target = 8'h00;
    endtask

    // Unconditional branch on bus0 followed by the single flush cycle.
    task automatic jump0(input logic [7:0] tgt);
        idle0();
        bus0.br_valid = 1; bus0.br_cond = 3'b000; bus0.br_target = tgt;
        step();
        idle0();
        step();
    endtask

    task automatic test_reset();
        idle0(); idle1();
        rst = 1;
        step();
        step();
        rst = 0;
        checks++; if (bus0.pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", bus0.pc); end
        checks++; if (bus0.flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", bus0.flags); end
        checks++; if (bus0.taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bus0.taken); end
        checks++; if (bus0.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus0.flush); end
        checks++; if (bus0.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus0.ready); end
    endtask

    task automatic test_increment();
        logic [7:0] exp_pc;
        bus0.pc_en = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_pc = 8'(i);
            checks++; if (bus0.pc !== exp_pc) begin errors++; $display("FAIL incr_pc got %h exp %h", bus0.pc, exp_pc); end
            checks++; if (bus0.taken !== 1'b0 || bus0.ready !== 1'b1) begin
                errors++; $display("FAIL incr_status taken %b ready %b exp 0 1", bus0.taken, bus0.ready);
            end
        end
        bus0.pc_en = 0;
    endtask

    task automatic test_eq_branch();
        bus0.flag_we = 1; bus0.z_in = 1; bus0.s_in = 0; bus0.v_in = 0;
        step();
        idle0();
        checks++; if (bus0.flags !== 3'b100) begin errors++; $display("FAIL eq_flags got %b exp 100", bus0.flags); end
        checks++; if (bus0.pc !== 8'h03) begin errors++; $display("FAIL eq_pc_hold got %h exp 03", bus0.pc); end
        bus0.br_valid = 1; bus0.br_cond = 3'b001; bus0.br_target = 8'h40; bus0.pc_en = 1;
        step();
        checks++; if (bus0.pc !== 8'h40) begin errors++; $display("FAIL eq_redirect_pc got %h exp 40", bus0.pc); end
        checks++; if ({bus0.taken, bus0.flush, bus0.ready} !== 3'b110) begin
            errors++; $display("FAIL eq_redirect_status taken/flush/ready got %b exp 110", {bus0.taken, bus0.flush, bus0.ready});
        end
        idle0();
        bus0.pc_en = 1;
        step();
        checks++; if (bus0.pc !== 8'h40) begin errors++; $display("FAIL eq_flush_hold got %h exp 40", bus0.pc); end
        checks++; if ({bus0.taken, bus0.flush, bus0.ready} !== 3'b001) begin
            errors++; $display("FAIL eq_after_flush taken/flush/ready got %b exp 001", {bus0.taken, bus0.flush, bus0.ready});
        end
        step();
        checks++; if (bus0.pc !== 8'h41) begin errors++; $display("FAIL eq_resume got %h exp 41", bus0.pc); end
        idle0();
    endtask

    task automatic test_lt();
        jump0(8'h10);
        bus0.flag_we = 1; bus0.z_in = 0; bus0.s_in = 1; bus0.v_in = 0;
        step();
        idle0();
        checks++; if (bus0.flags !== 3'b010) begin errors++; $display("FAIL lt_flags got %b exp 010", bus0.flags); end
        bus0.br_valid = 1; bus0.br_cond = 3'b011; bus0.br_target = 8'h20; bus0.pc_en = 1;
        step();
        checks++; if (bus0.pc !== 8'h20 || bus0.taken !== 1'b1) begin
            errors++; $display("FAIL lt_taken pc %h taken %b exp 20 1", bus0.pc, bus0.taken);
        end
        idle0();
        step();
        jump0(8'h10);
        bus0.flag_we = 1; bus0.z_in = 0; bus0.s_in = 1; bus0.v_in = 1;
        step();
        idle0();
        checks++; if (bus0.flags !== 3'b011) begin errors++; $display("FAIL lt_flags2 got %b exp 011", bus0.flags); end
        bus0.br_valid = 1; bus0.br_cond = 3'b011; bus0.br_target = 8'h20; bus0.pc_en = 1;
        step();
        checks++; if (bus0.pc !== 8'h11 || bus0.taken !== 1'b0 || bus0.ready !== 1'b1) begin
            errors++; $display("FAIL lt_not_taken pc %h taken %b ready %b exp 11 0 1", bus0.pc, bus0.taken, bus0.ready);
        end
        idle0();
    endtask

    task automatic test_no_forward();
        bus0.flag_we = 1; bus0.z_in = 1; bus0.s_in = 0; bus0.v_in = 0;
        bus0.br_valid = 1; bus0.br_cond = 3'b001; bus0.br_target = 8'h55; bus0.pc_en = 1;
        step();
        idle0();
        checks++; if (bus0.pc !== 8'h12 || bus0.taken !== 1'b0 || bus0.flush !== 1'b0) begin
            errors++; $display("FAIL nofwd_branch pc %h taken %b flush %b exp 12 0 0", bus0.pc, bus0.taken, bus0.flush);
        end
        checks++; if (bus0.flags !== 3'b100) begin errors++; $display("FAIL nofwd_flags got %b exp 100", bus0.flags); end
    endtask

    task automatic test_wrap();
        jump0(8'hFF);
        checks++; if (bus0.pc !== 8'hFF) begin errors++; $display("FAIL wrap_setup got %h exp ff", bus0.pc); end
        bus0.pc_en = 1;
        step();
        idle0();
        checks++; if (bus0.pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h exp 00", bus0.pc); end
    endtask

    task automatic test_flush3();
        logic [3:0] exp_flush;
        idle1();
        bus1.br_valid = 1; bus1.br_cond = 3'b000; bus1.br_target = 8'h80;
        step();
        checks++; if (bus1.pc !== 8'h80 || bus1.taken !== 1'b1) begin
            errors++; $display("FAIL f3_redirect pc %h taken %b exp 80 1", bus1.pc, bus1.taken);
        end
        bus1.br_target = 8'h33; bus1.pc_en = 1;
        exp_flush = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus1.flush !== exp_flush[3-i] || bus1.ready !== !exp_flush[3-i]) begin
                errors++; $display("FAIL f3_window cycle %0d flush %b ready %b exp flush %b", i, bus1.flush, bus1.ready, exp_flush[3-i]);
            end
            checks++; if (bus1.pc !== 8'h80) begin errors++; $display("FAIL f3_pc_hold cycle %0d got %h exp 80", i, bus1.pc); end
            if (i > 0) begin
                checks++; if (bus1.taken !== 1'b0) begin errors++; $display("FAIL f3_taken cycle %0d got %b exp 0", i, bus1.taken); end
            end
            if (i == 2) idle1();
            if (i < 3) step();
        end
        idle1();
    endtask

    task automatic test_reset_mid_flush();
        idle0();
        bus0.br_valid = 1; bus0.br_cond = 3'b000; bus0.br_target = 8'h70;
        step();
        idle0();
        checks++; if (bus0.flush !== 1'b1 || bus0.pc !== 8'h70) begin
            errors++; $display("FAIL rstflush_setup flush %b pc %h exp 1 70", bus0.flush, bus0.pc);
        end
        rst = 1;
        step();
        rst = 0;
        checks++; if (bus0.pc !== 8'h00 || bus0.flush !== 1'b0 || bus0.ready !== 1'b1 || bus0.taken !== 1'b0) begin
            errors++; $display("FAIL rstflush pc %h flush %b ready %b taken %b exp 00 0 1 0", bus0.pc, bus0.flush, bus0.ready, bus0.taken);
        end
        checks++; if (bus0.flags !== 3'b000) begin errors++; $display("FAIL rstflush_flags got %b exp 000", bus0.flags); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        test_reset();
        test_increment();
        test_eq_branch();
        test_lt();
        test_no_forward();
        test_wrap();
        test_flush3();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
